// File: rtl/dff_bank_init_controller.sv
// dff_bank_init_controller: forces a masked pattern into a preset/clear DFF bank, then reads it back
// Ports: c clock; clear async active-high reset; start/pattern/mask request an operation;
//        q_fb bank Q readback; preset_n/clear_n active-low force lines; hold_clk gates the bank clock;
//        busy operation in progress; done one-cycle completion; error/mismatch sticky readback result.
module dff_bank_init_controller #(
    parameter int WIDTH         = 8,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             c,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] preset_n,
    output logic [WIDTH-1:0] clear_n,
    output logic             hold_clk,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] mismatch
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FORCE  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] CHECK  = 2'd3;
    localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] S_LD = CW'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d, msk_q, msk_d;
    logic [WIDTH-1:0] pre_q, pre_d, clr_q, clr_d, mis_q, mis_d;
    logic             hold_q, hold_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             accept, last;
    logic [WIDTH-1:0] chk;

    always_comb begin
        accept  = (state_q == IDLE) && start;
        last    = (cnt_q == '0);
        chk     = (q_fb ^ pat_q) & msk_q;
        pat_d   = accept ? pattern : pat_q;
        msk_d   = accept ? mask : msk_q;
        state_d = accept                       ? ((|mask) ? FORCE : IDLE) :
                  (state_q == FORCE  && last)  ? SETTLE :
                  (state_q == SETTLE && last)  ? CHECK  :
                  (state_q == CHECK)           ? IDLE   : state_q;
        // counter reloads on entry to each timed state, counts down inside it
        cnt_d   = accept                                     ? P_LD :
                  (state_q == FORCE && last)                 ? S_LD :
                  (state_q == FORCE || state_q == SETTLE)    ? cnt_q - CW'(1) : cnt_q;
        // lines are decided from the next state so they appear registered in the first FORCE cycle
        pre_d   = (state_d == FORCE) ? ~(msk_d & pat_d)  : '1;
        clr_d   = (state_d == FORCE) ? ~(msk_d & ~pat_d) : '1;
        hold_d  = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (accept && !(|mask)) || (state_q == CHECK);
        mis_d   = accept ? '0   : (state_q == CHECK) ? chk    : mis_q;
        err_d   = accept ? 1'b0 : (state_q == CHECK) ? |chk   : err_q;
    end

    always_ff @(posedge c or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            msk_q   <= '0;
            pre_q   <= '1;
            clr_q   <= '1;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            msk_q   <= msk_d;
            pre_q   <= pre_d;
            clr_q   <= clr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign preset_n = pre_q;
    assign clear_n  = clr_q;
    assign hold_clk = hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;
    assign mismatch = mis_q;
endmodule

// File: tb/tb_dff_bank_init_controller.sv
// tb_dff_bank_init_controller: vector table, corner sequences and random run against a phase-based model
module tb_dff_bank_init_controller;
    localparam int P = 2;
    localparam int S = 1;
    localparam int D = P + S + 2;

    logic c = 1'b0, clear = 1'b0, start = 1'b0;
    logic [7:0] pattern = '0, mask = '0, q_fb;
    logic [7:0] preset_n, clear_n, mismatch;
    logic hold_clk, busy, done, error;
    logic [7:0] bank = '0, stuck = '0, load_val = '0;
    logic load_en = 1'b0;
    int errors = 0, checks = 0;

    dff_bank_init_controller #(.WIDTH(8), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .c(c), .clear(clear), .start(start), .pattern(pattern), .mask(mask), .q_fb(q_fb),
        .preset_n(preset_n), .clear_n(clear_n), .hold_clk(hold_clk), .busy(busy),
        .done(done), .error(error), .mismatch(mismatch)
    );

    always #5 c = ~c;

    always @(negedge c) bank <= load_en ? load_val : ((bank | ~preset_n) & clear_n);
    assign q_fb = bank & ~stuck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [7:0] v);
        @(negedge c);
        load_val = v;
        load_en  = 1'b1;
        @(negedge c);
        #1 load_en = 1'b0;
    endtask

    typedef struct {
        logic [7:0] pat, msk, stk, pre_val, e_pre, e_clr, e_q, e_mis;
        logic       e_err;
    } vec_t;
    vec_t tv[5];

    logic [7:0] lp, lm, e_mis;
    logic       e_err, empty;
    int         a, ndone;

    initial begin
        tv[0] = '{8'hA5, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'hA5, 8'hA5, 8'h00, 1'b0};
        tv[1] = '{8'hF3, 8'h0F, 8'h00, 8'h00, 8'hFC, 8'hF3, 8'h03, 8'h00, 1'b0};
        tv[2] = '{8'hFF, 8'hFF, 8'h04, 8'h00, 8'h00, 8'hFF, 8'hFB, 8'h04, 1'b1};
        tv[3] = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'hFF, 8'h3C, 8'h3C, 8'h00, 1'b0};
        tv[4] = '{8'h0F, 8'h81, 8'h81, 8'h00, 8'hFE, 8'h7F, 8'h00, 8'h01, 1'b1};

        // reset with random inputs
        @(negedge c);
        clear = 1'b1; start = 1'($urandom); pattern = 8'($urandom); mask = 8'($urandom);
        repeat (2) @(negedge c);
        chk("rst_pre", preset_n, 8'hFF); chk("rst_clr", clear_n, 8'hFF);
        chk("rst_flags", {busy, done, error, hold_clk}, 4'b0); chk("rst_mis", mismatch, 8'h00);
        start = 1'b0; clear = 1'b0;
        @(negedge c);
        chk("rel_pre", preset_n, 8'hFF); chk("rel_clr", clear_n, 8'hFF);
        chk("rel_flags", {busy, done, error, hold_clk}, 4'b0); chk("rel_mis", mismatch, 8'h00);

        for (int i = 0; i < 5; i++) begin
            preload(tv[i].pre_val);
            @(negedge c);
            stuck = tv[i].stk; pattern = tv[i].pat; mask = tv[i].msk; start = 1'b1;
            @(negedge c);
            start = 1'b0; pattern = ~tv[i].pat; mask = 8'($urandom);
            for (int k = 1; k <= 7; k++) begin
                chk($sformatf("v%0d_pre_k%0d", i, k), preset_n, (k <= P) ? tv[i].e_pre : 8'hFF);
                chk($sformatf("v%0d_clr_k%0d", i, k), clear_n, (k <= P) ? tv[i].e_clr : 8'hFF);
                chk($sformatf("v%0d_ctl_k%0d", i, k), {busy, hold_clk, done},
                    (k < D) ? 3'b110 : (k == D) ? 3'b001 : 3'b000);
                if (k >= D) begin
                    chk($sformatf("v%0d_mis_k%0d", i, k), mismatch, tv[i].e_mis);
                    chk($sformatf("v%0d_err_k%0d", i, k), error, tv[i].e_err);
                    chk($sformatf("v%0d_q_k%0d", i, k), q_fb, tv[i].e_q);
                end
                @(negedge c);
            end
        end

        // empty mask: immediate done, sticky results cleared, nothing driven
        pattern = 8'h55; mask = 8'h00; start = 1'b1;
        @(negedge c);
        start = 1'b0;
        chk("empty_done", {done, busy, hold_clk}, 3'b100);
        chk("empty_lines", {preset_n, clear_n}, 16'hFFFF);
        chk("empty_clr", {error, mismatch}, 9'h000);
        @(negedge c);
        chk("empty_after", {done, busy, hold_clk}, 3'b000);
        stuck = 8'h00;

        // overlapping start during FORCE is ignored
        @(negedge c);
        pattern = 8'h96; mask = 8'hFF; start = 1'b1;
        @(negedge c);
        start = 1'b0; ndone = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 2) start = 1'b1;
            if (k == 4) start = 1'b0;
            if (done) begin
                ndone++;
                chk("ovl_done_cycle", k, D);
            end
            @(negedge c);
        end
        chk("ovl_ndone", ndone, 1);

        // reset mid-FORCE aborts immediately with no done afterwards
        pattern = 8'h0F; mask = 8'hFF; start = 1'b1;
        @(negedge c);
        start = 1'b0;
        chk("abort_forcing", busy, 1'b1);
        #2 clear = 1'b1;
        #1;
        chk("abort_lines", {preset_n, clear_n}, 16'hFFFF);
        chk("abort_flags", {busy, hold_clk, done}, 3'b000);
        @(negedge c);
        clear = 1'b0; ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge c);
            if (done || busy) ndone++;
        end
        chk("abort_quiet", ndone, 0);

        // random run against a phase model: a = cycles since accept, 0 when idle
        a = 0; empty = 1'b0; e_mis = '0; e_err = 1'b0; lp = '0; lm = '0;
        for (int n = 0; n < 600; n++) begin
            chk("rand", {preset_n, clear_n, busy, hold_clk, done, error, mismatch},
                {(a >= 1 && a <= P) ? ~(lm & lp) : 8'hFF,
                 (a >= 1 && a <= P) ? ~(lm & ~lp) : 8'hFF,
                 a >= 1 && a < D, a >= 1 && a < D, (a == D) || empty, e_err, e_mis});
            if (a == 0 || a == D) stuck = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            start   = ($urandom_range(2) != 0);
            pattern = 8'($urandom);
            mask    = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
            if ((a == 0 || a == D) && start) begin
                lp = pattern; lm = mask; e_mis = '0; e_err = 1'b0;
                empty = (mask == 8'h00);
                a = empty ? 0 : 1;
            end else begin
                empty = 1'b0;
                if (a == D) a = 0;
                else if (a > 0) begin
                    if (a == D - 1) begin
                        e_mis = lm & lp & stuck;
                        e_err = |(lm & lp & stuck);
                    end
                    a++;
                end
            end
            @(negedge c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
